// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal) with valid/ready handshakes,
// optional two-bit zero tail per frame and a wrapping completed-frame counter.
module conv_encoder_k3 #(
    parameter bit TAIL_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic             s_bit_i,
    input  logic             s_last_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [1:0]       m_sym_o,
    output logic             m_tail_o,
    output logic             m_last_o,
    output logic [CNT_W-1:0] frames_o
);

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } state_t;

    state_t     state, state_n;
    logic       tail_cnt, tail_cnt_n;
    logic [1:0] sr, sr_n;
    logic       rst_done;
    logic       slot_free;
    logic       load, ld_u, ld_tail, ld_last;
    logic [1:0] ld_sym;

    assign slot_free = !m_valid_o || m_ready_i;

    // NOTE: every output of this block gets a default before the case, so no latch can be inferred.
    always_comb begin
        state_n    = state;
        tail_cnt_n = tail_cnt;
        sr_n       = sr;
        s_ready_o  = 1'b0;
        load       = 1'b0;
        ld_u       = 1'b0;
        ld_tail    = 1'b0;
        ld_last    = 1'b0;
        case (state)
            DATA: begin
                s_ready_o = rst_done && slot_free;
                if (s_valid_i && s_ready_o) begin
                    load = 1'b1;
                    ld_u = s_bit_i;
                    sr_n = {s_bit_i, sr[1]};
                    if (s_last_i) begin
                        if (TAIL_EN) begin
                            state_n    = TAIL;
                            tail_cnt_n = 1'b0;
                        end else begin
                            // Untailed frames restart the trellis from S0.
                            ld_last = 1'b1;
                            sr_n    = 2'b00;
                        end
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    load    = 1'b1;
                    ld_tail = 1'b1;
                    sr_n    = {1'b0, sr[1]};
                    if (tail_cnt == 1'b0) begin
                        tail_cnt_n = 1'b1;
                    end else begin
                        ld_last    = 1'b1;
                        tail_cnt_n = 1'b0;
                        state_n    = DATA;
                    end
                end
            end
            default: state_n = DATA;
        endcase
        ld_sym = {ld_u ^ sr[1] ^ sr[0], ld_u ^ sr[0]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DATA;
            tail_cnt <= 1'b0;
            sr       <= 2'b00;
            rst_done <= 1'b0;
        end else begin
            state    <= state_n;
            tail_cnt <= tail_cnt_n;
            sr       <= sr_n;
            rst_done <= 1'b1;
        end
    end

    // Single output slot: reload, drain, or hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_o <= 1'b0;
            m_sym_o   <= 2'b00;
            m_tail_o  <= 1'b0;
            m_last_o  <= 1'b0;
        end else if (load) begin
            m_valid_o <= 1'b1;
            m_sym_o   <= ld_sym;
            m_tail_o  <= ld_tail;
            m_last_o  <= ld_last;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_o <= '0;
        end else if (m_valid_o && m_ready_i && m_last_o) begin
            frames_o <= frames_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Self-checking bench for conv_encoder_k3: directed frames, backpressure, mid-frame reset,
// untailed build, random back-to-back frames against a scoreboard, and a 2-bit counter wrap.
module tb_conv_encoder_k3;

    typedef struct packed {
        logic [1:0] sym;
        logic       tail;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0, s_bit = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic        s_ready_o, m_valid_o, m_tail_o, m_last_o;
    logic [1:0]  m_sym_o;
    logic [15:0] frames_o;

    logic        w_s_ready, w_m_valid, w_m_tail, w_m_last;
    logic [1:0]  w_m_sym, w_frames;

    logic        nt_valid = 1'b0, nt_bit = 1'b0, nt_last = 1'b0, nt_ready = 1'b1;
    logic        nt_s_ready, nt_m_valid, nt_m_tail, nt_m_last;
    logic [1:0]  nt_sym;
    logic [15:0] nt_frames;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q[$];
    logic [1:0]  seen[$];
    logic [1:0]  msr = 2'b00;
    logic        bp_mode = 1'b0;
    logic        mon_en = 1'b1;
    logic        wrap_seen = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;

    always #5 clk = ~clk;

    conv_encoder_k3 #(.TAIL_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
        .s_bit_i(s_bit), .s_last_i(s_last), .m_valid_o(m_valid_o), .m_ready_i(m_ready),
        .m_sym_o(m_sym_o), .m_tail_o(m_tail_o), .m_last_o(m_last_o), .frames_o(frames_o)
    );

    conv_encoder_k3 #(.TAIL_EN(1'b1), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .s_valid_i(s_valid), .s_ready_o(w_s_ready),
        .s_bit_i(s_bit), .s_last_i(s_last), .m_valid_o(w_m_valid), .m_ready_i(m_ready),
        .m_sym_o(w_m_sym), .m_tail_o(w_m_tail), .m_last_o(w_m_last), .frames_o(w_frames)
    );

    conv_encoder_k3 #(.TAIL_EN(1'b0), .CNT_W(16)) dut_nt (
        .clk(clk), .rst_n(rst_n), .s_valid_i(nt_valid), .s_ready_o(nt_s_ready),
        .s_bit_i(nt_bit), .s_last_i(nt_last), .m_valid_o(nt_m_valid), .m_ready_i(nt_ready),
        .m_sym_o(nt_sym), .m_tail_o(nt_m_tail), .m_last_o(nt_m_last), .frames_o(nt_frames)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: G0 = u^s1^s0, G1 = u^s0, state <= {u, s1}.
    task automatic model_push(input logic u, input logic tail, input logic last);
        exp_t e;
        e.sym  = {u ^ msr[1] ^ msr[0], u ^ msr[0]};
        e.tail = tail;
        e.last = last;
        q.push_back(e);
        msr = {u, msr[1]};
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_bit(input logic b, input logic l);
        logic done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_bit   = b;
        s_last  = l;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (s_ready_o) begin
                model_push(b, 1'b0, 1'b0);
                if (l) begin
                    model_push(1'b0, 1'b1, 1'b0);
                    model_push(1'b0, 1'b1, 1'b1);
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("accept_timeout", done, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q.size() != 0 || m_valid_o); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_valid_low", m_valid_o, 0);
    endtask

    task automatic check_seen(input string tag, input logic [11:0] exp_syms, input int n);
        logic [11:0] e;
        e = exp_syms;
        check({tag, "_count"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            check({tag, "_sym"}, seen[i], e[2*(n-1-i) +: 2]);
    endtask

    // Output monitor: scoreboard pop on handshake, hold check while stalled.
    initial begin
        logic       held;
        logic [4:0] held_val;
        exp_t       e;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                held = 1'b0;
            end else begin
                if (held)
                    check("stall_hold", {m_valid_o, m_sym_o, m_tail_o, m_last_o}, held_val);
                if (m_valid_o && m_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_symbol", m_valid_o, 0);
                    end else begin
                        e = q.pop_front();
                        check("sym", m_sym_o, e.sym);
                        check("tail", m_tail_o, e.tail);
                        check("last", m_last_o, e.last);
                        seen.push_back(m_sym_o);
                    end
                end
                if (m_valid_o && !m_ready)
                    check("s_ready_low_stalled", s_ready_o, 0);
                held     = m_valid_o && !m_ready;
                held_val = {m_valid_o, m_sym_o, m_tail_o, m_last_o};
            end
        end
    end

    // Backpressure driver: m_ready follows the 1,0,0,1 pattern while enabled.
    initial begin
        int idx;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                m_ready = bp_pat[3 - (idx % 4)];
                idx++;
            end
        end
    end

    initial begin
        logic [1:0] prev_w;
        prev_w = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && prev_w == 2'd3 && w_frames == 2'd0) wrap_seen = 1'b1;
            prev_w = w_frames;
        end
    end

    initial begin
        int len;
        // Reset asserted between edges: outputs must clear immediately.
        #3 rst_n = 1'b0;
        #1;
        check("rst_s_ready", s_ready_o, 0);
        check("rst_m_valid", m_valid_o, 0);
        check("rst_m_sym", m_sym_o, 0);
        check("rst_m_tail", m_tail_o, 0);
        check("rst_m_last", m_last_o, 0);
        check("rst_frames", frames_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", s_ready_o, 1);
        check("post_rst_m_valid", m_valid_o, 0);

        // Frame 1,0,1,1 at full rate.
        seen.delete();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        drain();
        check_seen("frame1011", {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11}, 6);
        check("frames_after_f1", frames_o, 1);

        // Single-bit frame: ready low for exactly two cycles.
        seen.delete();
        send_bit(1'b1, 1'b1);
        check("single_ready_c1", s_ready_o, 0);
        @(posedge clk);
        #1;
        check("single_ready_c2", s_ready_o, 0);
        @(posedge clk);
        #1;
        check("single_ready_c3", s_ready_o, 1);
        drain();
        check_seen("single", {6'b0, 2'b11, 2'b10, 2'b11}, 3);
        check("frames_after_single", frames_o, 2);

        // Same 4-bit frame under 1,0,0,1 backpressure.
        seen.delete();
        bp_mode = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        drain();
        bp_mode = 1'b0;
        m_ready = 1'b1;
        check_seen("backpressure", {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11}, 6);
        check("frames_after_bp", frames_o, 3);

        // Reset in the middle of a frame drops it and clears everything.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid_o, 0);
        check("midrst_m_sym", m_sym_o, 0);
        check("midrst_s_ready", s_ready_o, 0);
        check("midrst_frames", frames_o, 0);
        q.delete();
        msr = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wrap_seen = 1'b0;
        check("midrst_post_s_ready", s_ready_o, 1);
        check("midrst_post_m_valid", m_valid_o, 0);

        // Untailed build: 1,1(last) then 1(last).
        nt_valid = 1'b1; nt_bit = 1'b1; nt_last = 1'b0;
        check("nt_s_ready", nt_s_ready, 1);
        @(posedge clk);
        #1;
        check("nt_sym0", nt_sym, 2'b11);
        check("nt_last0", nt_m_last, 0);
        nt_bit = 1'b1; nt_last = 1'b1;
        @(posedge clk);
        #1;
        check("nt_sym1", nt_sym, 2'b01);
        check("nt_last1", nt_m_last, 1);
        check("nt_tail1", nt_m_tail, 0);
        nt_bit = 1'b1; nt_last = 1'b1;
        @(posedge clk);
        #1;
        check("nt_sym2", nt_sym, 2'b11);
        check("nt_last2", nt_m_last, 1);
        check("nt_frames_mid", nt_frames, 1);
        nt_valid = 1'b0; nt_last = 1'b0;
        @(posedge clk);
        #1;
        check("nt_valid_drained", nt_m_valid, 0);
        check("nt_frames", nt_frames, 2);

        // 200 random frames of 1..64 bits, back to back at full rate.
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 64);
            for (int i = 0; i < len; i++)
                send_bit(1'($urandom_range(0, 1)), (i == len - 1));
        end
        drain();
        check("rand_frames", frames_o, 200);
        check("rand_frames_w", w_frames, 2'd0);
        check("wrap_3_to_0", wrap_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
